ihex_dump_engine: RTL

- Synthesizable memory-dump engine that takes ownership of a CPU RAM read port and walks a parametrised address window, one word per read.
- Formats each word as an Intel HEX ASCII record, including extended-linear-address records and the EOF record.
- Streams the characters over a byte valid/ready interface, e.g. to a UART TX, so post-halt RAM dumps work on silicon and not only in simulation.
- Sits beside the system RAM arbiter and drives its override-control input.

---
 rtl/ihex_dump_engine_pkg.sv | 33 +++
 rtl/ihex_dump_engine_if.sv | 24 ++
 rtl/ihex_dump_engine_record_serializer.sv | 88 ++++++++
 rtl/ihex_dump_engine.sv | 151 +++++++++++++++
 4 files changed

// File: rtl/ihex_dump_engine_pkg.sv
// Shared types and helpers for the Intel HEX dump engine: record types,
// FSM state encoding and ASCII helpers.
package ihex_dump_engine_pkg;

  typedef enum logic [7:0] {
    DATA = 8'h00,
    EOF  = 8'h01,
    ELA  = 8'h04
  } ihex_rectype_t;

  typedef enum logic [3:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    CHECK,
    EMIT_ELA,
    EMIT_DATA,
    NEXT,
    EMIT_EOF,
    FINISH
  } dump_state_t;

  localparam logic [7:0] ASCII_COLON = 8'h3A;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  // Byte slots in a record: LL, AH, AL, TT, up to 8 data bytes, CC (rounded up).
  localparam int MAX_REC_BYTES = 16;

  function automatic logic [7:0] nibble_to_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

endpackage

// File: rtl/ihex_dump_engine_if.sv
// RAM read port and character stream of the dump engine.
// master = engine side, slave = RAM/arbiter and character sink side.
interface ihex_dump_engine_if #(
  parameter int ADDR_W     = 32,
  parameter int WORD_BYTES = 4
);
  logic                    mem_ren;
  logic [ADDR_W-1:0]       mem_addr;
  logic                    mem_wait;
  logic [8*WORD_BYTES-1:0] mem_rdata;
  logic [7:0]              tx_data;
  logic                    tx_valid;
  logic                    tx_ready;

  modport master (
    output mem_ren, mem_addr, tx_data, tx_valid,
    input  mem_wait, mem_rdata, tx_ready
  );

  modport slave (
    input  mem_ren, mem_addr, tx_data, tx_valid,
    output mem_wait, mem_rdata, tx_ready
  );
endinterface

// File: rtl/ihex_dump_engine_record_serializer.sv
// Turns one {type, addr16, data, length} record into the ASCII line
// ":LLAAAATT<data>CC\n", one character per valid/ready handshake.
module ihex_record_serializer
  import ihex_dump_engine_pkg::*;
(
  input  logic          clk,
  input  logic          nrst,
  input  logic          load,
  input  ihex_rectype_t rectype,
  input  logic [15:0]   addr16,
  input  logic [63:0]   data,      // left-justified, data[63:56] is sent first
  input  logic [3:0]    len,
  output logic          busy,
  output logic          last_hs,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready
);

  logic [7:0] data_byte  [8];
  logic [7:0] bytes_load [MAX_REC_BYTES];
  logic [7:0] bytes_reg  [MAX_REC_BYTES];
  logic [7:0] sum;
  logic       busy_reg;
  logic [4:0] idx_reg;
  logic [4:0] last_reg;
  logic [4:0] pos;
  logic [7:0] cur_byte;
  logic [3:0] nib;
  logic [7:0] char_c;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_data_byte
      assign data_byte[gi] = data[63-8*gi -: 8];
    end
  endgenerate

  // Whole record image, checksum included, is built at load time.
  always_comb begin
    sum = 8'(len) + addr16[15:8] + addr16[7:0] + 8'(rectype);
    for (int i = 0; i < MAX_REC_BYTES; i++) bytes_load[i] = 8'h00;
    bytes_load[0] = 8'(len);
    bytes_load[1] = addr16[15:8];
    bytes_load[2] = addr16[7:0];
    bytes_load[3] = 8'(rectype);
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < len) begin
        bytes_load[4+i] = data_byte[i];
        sum             = sum + data_byte[i];
      end
    end
    bytes_load[4'd4 + len] = 8'h00 - sum;
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      busy_reg <= 1'b0;
      idx_reg  <= '0;
      last_reg <= '0;
      for (int i = 0; i < MAX_REC_BYTES; i++) bytes_reg[i] <= 8'h00;
    end else if (load && !busy_reg) begin
      busy_reg <= 1'b1;
      idx_reg  <= '0;
      last_reg <= 5'd11 + {len, 1'b0};
      for (int i = 0; i < MAX_REC_BYTES; i++) bytes_reg[i] <= bytes_load[i];
    end else if (busy_reg && tx_ready) begin
      if (idx_reg == last_reg) busy_reg <= 1'b0;
      else                     idx_reg  <= idx_reg + 5'd1;
    end
  end

  // Character 0 is ':', the last is LF, everything between is two hex digits per byte.
  always_comb begin
    pos      = idx_reg - 5'd1;
    cur_byte = bytes_reg[pos[4:1]];
    nib      = pos[0] ? cur_byte[3:0] : cur_byte[7:4];
    if (idx_reg == 5'd0)          char_c = ASCII_COLON;
    else if (idx_reg == last_reg) char_c = ASCII_LF;
    else                          char_c = nibble_to_ascii(nib);
  end

  assign busy     = busy_reg;
  assign tx_valid = busy_reg;
  assign tx_data  = busy_reg ? char_c : 8'h00;
  assign last_hs  = busy_reg && tx_ready && (idx_reg == last_reg);

endmodule

// File: rtl/ihex_dump_engine.sv
// Memory dump engine: owns the RAM read port while busy, walks an address
// window and streams every word as Intel HEX, ending with an EOF record.
module ihex_dump_engine
  import ihex_dump_engine_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int WORD_BYTES = 4,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              start,
  input  logic              skip_zero,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  output logic              busy,
  output logic              done,
  output logic              override_ctrl,
  output logic [CNT_W-1:0]  rec_count,
  ihex_dump_engine_if.master bus
);

  localparam int                WB_BITS    = 8 * WORD_BYTES;
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~(ADDR_W'(WORD_BYTES - 1));
  localparam logic [ADDR_W-1:0] STEP       = ADDR_W'(WORD_BYTES);

  dump_state_t         state_reg, state_next;
  logic [ADDR_W-1:0]   addr_reg;
  logic [CNT_W-1:0]    remaining_reg;
  logic                skip_reg;
  logic [WB_BITS-1:0]  word_reg;
  logic [15:0]         ela_hi_reg;
  logic [CNT_W-1:0]    rec_count_reg;
  logic [15:0]         addr_hi;

  logic                ser_load;
  ihex_rectype_t       ser_type;
  logic [15:0]         ser_addr16;
  logic [63:0]         ser_data;
  logic [3:0]          ser_len;
  logic                ser_busy;
  logic                ser_last;
  logic [7:0]          ser_tx_data;
  logic                ser_tx_valid;

  // Zero for ADDR_W == 16, so the ELA comparison never fires there.
  assign addr_hi = 16'(addr_reg >> 16);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (start) state_next = (word_count == '0) ? EMIT_EOF : RD_REQ;
      RD_REQ:    state_next = RD_WAIT;
      RD_WAIT:   if (!bus.mem_wait) state_next = CHECK;
      CHECK: begin
        if (skip_reg && word_reg == '0)  state_next = NEXT;
        else if (addr_hi != ela_hi_reg)  state_next = EMIT_ELA;
        else                             state_next = EMIT_DATA;
      end
      EMIT_ELA:  if (ser_last) state_next = EMIT_DATA;
      EMIT_DATA: if (ser_last) state_next = NEXT;
      NEXT:      state_next = (remaining_reg == CNT_W'(1)) ? EMIT_EOF : RD_REQ;
      EMIT_EOF:  if (ser_last) state_next = FINISH;
      FINISH:    state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      addr_reg      <= '0;
      remaining_reg <= '0;
      skip_reg      <= 1'b0;
      word_reg      <= '0;
      ela_hi_reg    <= '0;
      rec_count_reg <= '0;
    end else begin
      if (state_reg == IDLE && start) begin
        addr_reg      <= base_addr & ALIGN_MASK;
        remaining_reg <= word_count;
        skip_reg      <= skip_zero;
        ela_hi_reg    <= '0;
        rec_count_reg <= '0;
      end
      if (state_reg == RD_WAIT && !bus.mem_wait) word_reg <= bus.mem_rdata;
      if (state_reg == CHECK && state_next == EMIT_ELA) ela_hi_reg <= addr_hi;
      if (state_reg == EMIT_DATA && ser_last) rec_count_reg <= rec_count_reg + CNT_W'(1);
      if (state_reg == NEXT) begin
        addr_reg      <= addr_reg + STEP;
        remaining_reg <= remaining_reg - CNT_W'(1);
      end
    end
  end

  // Each EMIT state loads the serializer once; it is idle again right after the LF handshake.
  always_comb begin
    busy          = (state_reg != IDLE) && (state_reg != FINISH);
    override_ctrl = busy;
    done          = (state_reg == FINISH);
    ser_load      = 1'b0;
    ser_type      = DATA;
    ser_addr16    = 16'(addr_reg);
    ser_data      = 64'(word_reg) << (64 - WB_BITS);
    ser_len       = 4'(WORD_BYTES);
    case (state_reg)
      EMIT_ELA: begin
        ser_load   = !ser_busy;
        ser_type   = ELA;
        ser_addr16 = 16'h0000;
        ser_data   = {ela_hi_reg, 48'h0};
        ser_len    = 4'd2;
      end
      EMIT_DATA: ser_load = !ser_busy;
      EMIT_EOF: begin
        ser_load   = !ser_busy;
        ser_type   = EOF;
        ser_addr16 = 16'h0000;
        ser_data   = 64'h0;
        ser_len    = 4'd0;
      end
      default: ;
    endcase
  end

  assign rec_count    = rec_count_reg;
  assign bus.mem_ren  = (state_reg == RD_REQ);
  assign bus.mem_addr = addr_reg;
  assign bus.tx_data  = ser_tx_data;
  assign bus.tx_valid = ser_tx_valid;

  ihex_record_serializer u_serializer (
    .clk      (clk),
    .nrst     (nrst),
    .load     (ser_load),
    .rectype  (ser_type),
    .addr16   (ser_addr16),
    .data     (ser_data),
    .len      (ser_len),
    .busy     (ser_busy),
    .last_hs  (ser_last),
    .tx_data  (ser_tx_data),
    .tx_valid (ser_tx_valid),
    .tx_ready (bus.tx_ready)
  );

endmodule
